w_schedule: RTL and testbench

- SHA-256 message schedule generator. Accepts one 512-bit message block and streams W[0]..W[63], one word per advancing cycle, to the round/compression stage.
- Holds a 16-word sliding window of W[t..t+15]. Words for t<16 come directly from the block.
- Words for t>=16 come from the combinational w_expand unit: W[t+16] = SSIG1(W[t+14]) + W[t+9] + SSIG0(W[t+1]) + W[t].
- Sits between the block loader (upstream) and the compression rounds (downstream).

---
 rtl/w_schedule_pkg.sv | 16 +
 rtl/w_expand.sv | 18 +
 rtl/w_schedule.sv | 91 +++++++++
 tb/tb_w_schedule.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/w_schedule_pkg.sv
// Shared SHA-256 sizing constants and the word rotate helper used by the
// message schedule.
package w_schedule_pkg;
    localparam int SHA256_WORD_W  = 32;
    localparam int SHA256_BLOCK_W = 512;
    localparam int SHA256_ROUNDS  = 64;
    localparam int SHA256_WINDOW  = 16;
    localparam int T_IDX_W        = 6;

    function automatic logic [SHA256_WORD_W-1:0] rotr(
        input logic [SHA256_WORD_W-1:0] x,
        input int unsigned              n
    );
        return (x >> n) | (x << (SHA256_WORD_W - n));
    endfunction
endpackage

// File: rtl/w_expand.sv
// Combinational SHA-256 schedule expansion:
// W[t] = SSIG1(W[t-2]) + W[t-7] + SSIG0(W[t-15]) + W[t-16], modulo 2^32.
module w_expand
    import w_schedule_pkg::*;
(
    input  logic [SHA256_WORD_W-1:0] i_w2,
    input  logic [SHA256_WORD_W-1:0] i_w7,
    input  logic [SHA256_WORD_W-1:0] i_w15,
    input  logic [SHA256_WORD_W-1:0] i_w16,
    output logic [SHA256_WORD_W-1:0] o_w_new
);
    logic [SHA256_WORD_W-1:0] w_ssig0;
    logic [SHA256_WORD_W-1:0] w_ssig1;

    assign w_ssig0 = rotr(i_w15, 7)  ^ rotr(i_w15, 18) ^ (i_w15 >> 3);
    assign w_ssig1 = rotr(i_w2, 17)  ^ rotr(i_w2, 19)  ^ (i_w2 >> 10);
    assign o_w_new = w_ssig1 + i_w7 + w_ssig0 + i_w16;
endmodule

// File: rtl/w_schedule.sv
// SHA-256 message schedule: loads a 512-bit block and streams W[0..ROUNDS-1]
// from a 16-word sliding window, one word per accepted (advance) cycle.
module w_schedule
    import w_schedule_pkg::*;
#(
    parameter int ROUNDS = SHA256_ROUNDS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [SHA256_BLOCK_W-1:0] block_in,
    input  logic                      advance,
    output logic                      busy,
    output logic                      w_valid,
    output logic [SHA256_WORD_W-1:0]  w_out,
    output logic [T_IDX_W-1:0]        t_idx,
    output logic                      last,
    output logic                      done
);
    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [T_IDX_W-1:0] T_LAST = T_IDX_W'(ROUNDS - 1);

    state_t                   r_state;
    logic [SHA256_WORD_W-1:0] r_win [SHA256_WINDOW];
    logic [T_IDX_W-1:0]       r_t;
    logic                     r_done;
    logic [SHA256_WORD_W-1:0] w_next;
    logic                     w_at_end;

    // Taps are relative to the word about to enter at window slot 15.
    w_expand u_expand (
        .i_w2    (r_win[14]),
        .i_w7    (r_win[9]),
        .i_w15   (r_win[1]),
        .i_w16   (r_win[0]),
        .o_w_new (w_next)
    );

    assign w_at_end = (r_t == T_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_t     <= '0;
            r_done  <= 1'b0;
            for (int i = 0; i < SHA256_WINDOW; i++) begin
                r_win[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < SHA256_WINDOW; i++) begin
                            r_win[i] <= block_in[SHA256_BLOCK_W-1-SHA256_WORD_W*i -: SHA256_WORD_W];
                        end
                        r_t     <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // The final accept retires the block without shifting.
                    if (advance) begin
                        if (w_at_end) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            for (int i = 0; i < SHA256_WINDOW - 1; i++) begin
                                r_win[i] <= r_win[i+1];
                            end
                            r_win[SHA256_WINDOW-1] <= w_next;
                            r_t <= r_t + T_IDX_W'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy    = (r_state == S_RUN);
    assign w_valid = (r_state == S_RUN);
    assign w_out   = r_win[0];
    assign t_idx   = r_t;
    assign last    = (r_state == S_RUN) && w_at_end;
    assign done    = r_done;
endmodule

// File: tb/tb_w_schedule.sv
// Scoreboard bench for w_schedule: expected {t, W} pairs are queued at start,
// and monitors pop and compare on every accepted word.
module tb_w_schedule;
  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] INJ_BLK = {16{32'h12345678}};
  localparam logic [511:0] FF_BLK  = {512{1'b1}};

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [511:0] block_in;
  logic         advance;
  logic         busy, w_valid, last, done;
  logic [31:0]  w_out;
  logic [5:0]   t_idx;

  logic         start16;
  logic [511:0] block16;
  logic         advance16;
  logic         busy16, w_valid16, last16, done16;
  logic [31:0]  w_out16;
  logic [5:0]   t_idx16;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done16_cnt = 0;
  int acc_cnt = 0;
  int last_cyc = -10;
  int last16_cyc = -10;
  bit rec_en = 0;
  bit have_hold = 0;
  logic [31:0] hold_w;
  logic [5:0]  hold_t;
  logic [31:0] m_w [64];
  logic [31:0] got_w [64];
  logic [37:0] exp_q[$];
  logic [37:0] exp16_q[$];
  logic [37:0] e, e16;
  bit got_done;

  w_schedule #(.ROUNDS(64)) u_dut (
    .clk(clk), .reset(reset), .start(start), .block_in(block_in),
    .advance(advance), .busy(busy), .w_valid(w_valid), .w_out(w_out),
    .t_idx(t_idx), .last(last), .done(done)
  );

  w_schedule #(.ROUNDS(16)) u_dut16 (
    .clk(clk), .reset(reset), .start(start16), .block_in(block16),
    .advance(advance16), .busy(busy16), .w_valid(w_valid16), .w_out(w_out16),
    .t_idx(t_idx16), .last(last16), .done(done16)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, cyc);
    end
  endtask

  task automatic build_model(input logic [511:0] blk);
    for (int t = 0; t < 64; t++) begin
      if (t < 16) m_w[t] = blk[511-32*t -: 32];
      else m_w[t] = ssig1(m_w[t-2]) + m_w[t-7] + ssig0(m_w[t-15]) + m_w[t-16];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: pulse start with a block and queue its expected stream
  task automatic issue_start(input logic [511:0] blk);
    build_model(blk);
    for (int t = 0; t < 64; t++) exp_q.push_back({6'(t), m_w[t]});
    start = 1'b1;
    block_in = blk;
    step();
    start = 1'b0;
  endtask

  // driver: stream until done, optional random stalls and a stray start at t=inj
  task automatic run_until_done(input bit stall, input int inj);
    bit injected;
    injected = 0;
    got_done = 0;
    for (int c = 0; c < 2000 && !got_done; c++) begin
      advance = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (inj >= 0 && !injected && w_valid && t_idx == 6'(inj)) begin
        start = 1'b1;
        block_in = INJ_BLK;
        injected = 1;
      end
      step();
      start = 1'b0;
      if (done) got_done = 1;
    end
    check("done_seen", 64'(got_done), 64'd1);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // monitor for the 64-round instance
  always @(negedge clk) begin
    if (reset) begin
      acc_cnt = 0;
      have_hold = 0;
    end else begin
      if (have_hold) begin
        check("stall_w_stable", 64'(w_out), 64'(hold_w));
        check("stall_t_stable", 64'(t_idx), 64'(hold_t));
        have_hold = 0;
      end
      if (w_valid && advance) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'(w_out), 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("w_out", 64'(w_out), 64'(e[31:0]));
          check("t_idx", 64'(t_idx), 64'(e[37:32]));
        end
        check("last", 64'(last), 64'(t_idx == 6'd63));
        if (rec_en) got_w[t_idx] = w_out;
        if (t_idx == 6'd63) last_cyc = cyc;
        acc_cnt++;
      end else if (w_valid) begin
        hold_w = w_out;
        hold_t = t_idx;
        have_hold = 1;
      end
      if (done) begin
        done_cnt++;
        check("accepts_per_block", 64'(acc_cnt), 64'd64);
        check("done_after_last", 64'(cyc), 64'(last_cyc + 1));
        check("busy_low_on_done", 64'(busy), 64'd0);
        acc_cnt = 0;
      end
    end
  end

  // monitor for the 16-round instance
  always @(negedge clk) begin
    if (!reset) begin
      if (w_valid16 && advance16) begin
        if (exp16_q.size() == 0) begin
          check("r16_unexpected_word", 64'(w_out16), 64'hDEAD);
        end else begin
          e16 = exp16_q.pop_front();
          check("r16_w_out", 64'(w_out16), 64'(e16[31:0]));
          check("r16_t_idx", 64'(t_idx16), 64'(e16[37:32]));
        end
        check("r16_last", 64'(last16), 64'(t_idx16 == 6'd15));
        if (t_idx16 == 6'd15) last16_cyc = cyc;
      end
      if (done16) begin
        done16_cnt++;
        check("r16_done_after_last", 64'(cyc), 64'(last16_cyc + 1));
      end
    end
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    advance = 1'b0;
    block_in = '0;
    start16 = 1'b0;
    block16 = '0;
    advance16 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(w_valid), 64'd0);
    check("rst_w_out", 64'(w_out), 64'd0);
    check("rst_t_idx", 64'(t_idx), 64'd0);
    check("rst_last_done", 64'({last, done}), 64'd0);
    reset = 1'b0;
    step();

    // abc block, advance tied high
    rec_en = 1;
    issue_start(ABC_BLK);
    run_until_done(1'b0, -1);
    rec_en = 0;
    check("abc_W0", 64'(got_w[0]), 64'h61626380);
    check("abc_W15", 64'(got_w[15]), 64'h00000018);
    check("abc_W16", 64'(got_w[16]), 64'h61626380);
    check("abc_W17", 64'(got_w[17]), 64'h000F0000);
    check("abc_W18", 64'(got_w[18]), 64'h7DA86405);
    check("abc_W19", 64'(got_w[19]), 64'h600003C6);
    advance = 1'b0;
    step();
    check("done_one_cycle", 64'(done), 64'd0);

    // same block with random stalls
    issue_start(ABC_BLK);
    run_until_done(1'b1, -1);
    advance = 1'b0;
    step();

    // stray start at t=10 must be ignored
    issue_start(ABC_BLK);
    run_until_done(1'b0, 10);
    step();

    // asynchronous reset at t=30 aborts the block
    issue_start(ABC_BLK);
    advance = 1'b1;
    for (int c = 0; c < 200 && t_idx != 6'd30; c++) step();
    check("reach_t30", 64'(t_idx), 64'd30);
    #2;
    reset = 1'b1;
    #1;
    check("abort_busy_valid", 64'({busy, w_valid}), 64'd0);
    check("abort_w_out", 64'(w_out), 64'd0);
    check("abort_t_idx", 64'(t_idx), 64'd0);
    check("abort_last_done", 64'({last, done}), 64'd0);
    exp_q.delete();
    step();
    step();
    reset = 1'b0;
    step();
    step();
    check("abort_no_done", 64'(done_cnt), 64'd3);
    issue_start(ABC_BLK);
    check("after_abort_W0", 64'(w_out), 64'h61626380);
    run_until_done(1'b0, -1);

    // back-to-back: start on the done cycle
    issue_start(ABC_BLK);
    run_until_done(1'b0, -1);
    issue_start(FF_BLK);
    check("b2b_valid", 64'(w_valid), 64'd1);
    check("b2b_W0", 64'(w_out), 64'hFFFFFFFF);
    check("b2b_t0", 64'(t_idx), 64'd0);
    run_until_done(1'b0, -1);
    advance = 1'b0;
    step();
    check("total_done", 64'(done_cnt), 64'd6);

    // ROUNDS=16 instance emits the raw block words
    for (int t = 0; t < 16; t++) exp16_q.push_back({6'(t), ABC_BLK[511-32*t -: 32]});
    start16 = 1'b1;
    block16 = ABC_BLK;
    step();
    start16 = 1'b0;
    for (int c = 0; c < 40 && done16_cnt == 0; c++) step();
    check("r16_done_cnt", 64'(done16_cnt), 64'd1);
    check("r16_queue_drained", 64'(exp16_q.size()), 64'd0);
    step();
    check("r16_idle", 64'({busy16, done16}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
